// File: rtl/elevator_scan_controller.sv
// -----------------------------------------------------------------------------
// elevator_scan_controller
//
// Multi-floor elevator controller. One call button per floor is latched into
// a pending-request mask, and requests are served with a SCAN policy: keep
// travelling in the current direction while requests remain on that side,
// then reverse. A shared counter times both the per-floor travel delay and
// the door-open dwell.
//
// Optional feature (macro ELEV_DOOR_HOLD_EN): adds a door_hold input. While
// it is high in DOOR_OPEN the dwell counter is held at 0, so the door stays
// open. A full dwell of DOOR_TICKS cycles runs after release.
//
// Ports:
//   clk           : clock, all state updates on the rising edge
//   rst           : synchronous active-high reset
//   call_in       : call buttons, bit i requests floor i (pulse or level)
//   door_hold     : (ELEV_DOOR_HOLD_EN only) keep the door open
//   current_floor : index of the floor last reached
//   pending       : outstanding-request mask
//   moving        : high while travelling up or down
//   dir_up        : last or current travel direction (1 = up)
//   door_open     : high while the door is open
//   idle          : high while idle
//   arrive        : one-cycle pulse on the edge after the door opens
// -----------------------------------------------------------------------------
module elevator_scan_controller #(
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = 4,
    parameter int MOVE_TICKS = 10000000,
    parameter int DOOR_TICKS = 20000000,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] call_in,
`ifdef ELEV_DOOR_HOLD_EN
    input  logic                  door_hold,
`endif
    output logic [FLOOR_W-1:0]    current_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  moving,
    output logic                  dir_up,
    output logic                  door_open,
    output logic                  idle,
    output logic                  arrive
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_MOVE_UP   = 2'd1,
        S_MOVE_DOWN = 2'd2,
        S_DOOR_OPEN = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]   MOVE_LAST = CNT_W'(MOVE_TICKS - 1);
    localparam logic [CNT_W-1:0]   DOOR_LAST = CNT_W'(DOOR_TICKS - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

    state_t                  state_reg, state_next;
    logic [FLOOR_W-1:0]      floor_reg, floor_next;
    logic [NUM_FLOORS-1:0]   pending_reg, pending_next;
    logic                    dir_up_reg, dir_up_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic                    door_seen_reg;
    logic                    arrive_reg;

    logic [NUM_FLOORS-1:0]   clear_mask;
    logic [NUM_FLOORS-1:0]   here_mask;
    logic [NUM_FLOORS-1:0]   step_mask;
    logic [NUM_FLOORS-1:0]   above_mask;
    logic [NUM_FLOORS-1:0]   below_mask;
    logic [FLOOR_W-1:0]      step_floor;
    logic                    any_above;
    logic                    any_below;
    logic                    call_here;
    logic                    req_here;
    logic                    req_step;
    logic                    hold_active;

    // Floor the car reaches at the end of the current travel interval.
    assign step_floor = (state_reg == S_MOVE_DOWN) ? (floor_reg - FLOOR_W'(1))
                                                   : (floor_reg + FLOOR_W'(1));

    // Per-floor decode of position, next position and request sides.
    // Comparing against the floor index avoids a variable-width bit select.
    for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor_masks
        assign here_mask[gi]  = (floor_reg == FLOOR_W'(gi));
        assign step_mask[gi]  = (step_floor == FLOOR_W'(gi));
        assign above_mask[gi] = (FLOOR_W'(gi) > floor_reg);
        assign below_mask[gi] = (FLOOR_W'(gi) < floor_reg);
    end

    assign any_above = |(pending_reg & above_mask);
    assign any_below = |(pending_reg & below_mask);
    assign call_here = |(call_in & here_mask);
    assign req_here  = |((pending_reg | call_in) & here_mask);
    assign req_step  = |((pending_reg | call_in) & step_mask);

`ifdef ELEV_DOOR_HOLD_EN
    assign hold_active = door_hold;
`else
    assign hold_active = 1'b0;
`endif

    always_comb begin
        state_next  = state_reg;
        floor_next  = floor_reg;
        dir_up_next = dir_up_reg;
        cnt_next    = cnt_reg;
        clear_mask  = '0;

        case (state_reg)
            S_IDLE: begin
                cnt_next = '0;
                if (req_here) begin
                    state_next = S_DOOR_OPEN;
                    clear_mask = here_mask;
                end else if (any_above && dir_up_reg) begin
                    state_next = S_MOVE_UP;
                end else if (any_below && !dir_up_reg) begin
                    state_next = S_MOVE_DOWN;
                end else if (any_above) begin
                    state_next  = S_MOVE_UP;
                    dir_up_next = 1'b1;
                end else if (any_below) begin
                    state_next  = S_MOVE_DOWN;
                    dir_up_next = 1'b0;
                end
            end

            S_MOVE_UP, S_MOVE_DOWN: begin
                if (cnt_reg == MOVE_LAST) begin
                    cnt_next = '0;
                    // Out-of-range step cannot happen with correct direction
                    // logic; if it does, stop in place rather than wrap.
                    if ((state_reg == S_MOVE_UP   && floor_reg == TOP_FLOOR) ||
                        (state_reg == S_MOVE_DOWN && floor_reg == '0)) begin
                        state_next = S_IDLE;
                    end else begin
                        floor_next = step_floor;
                        if (req_step) begin
                            state_next = S_DOOR_OPEN;
                            clear_mask = step_mask;
                        end
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            S_DOOR_OPEN: begin
                // Calls for the open floor are absorbed, never latched.
                clear_mask = here_mask;
                if (call_here || hold_active) begin
                    cnt_next = '0;
                end else if (cnt_reg == DOOR_LAST) begin
                    cnt_next = '0;
                    if (any_above && dir_up_reg) begin
                        state_next = S_MOVE_UP;
                    end else if (any_below && !dir_up_reg) begin
                        state_next = S_MOVE_DOWN;
                    end else if (any_above) begin
                        state_next  = S_MOVE_UP;
                        dir_up_next = 1'b1;
                    end else if (any_below) begin
                        state_next  = S_MOVE_DOWN;
                        dir_up_next = 1'b0;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase

        // Clear wins over a same-edge set for the floor being served.
        pending_next = (pending_reg | call_in) & ~clear_mask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            floor_reg     <= '0;
            pending_reg   <= '0;
            dir_up_reg    <= 1'b1;
            cnt_reg       <= '0;
            door_seen_reg <= 1'b0;
            arrive_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            floor_reg     <= floor_next;
            pending_reg   <= pending_next;
            dir_up_reg    <= dir_up_next;
            cnt_reg       <= cnt_next;
            // arrive fires on the first edge spent inside DOOR_OPEN.
            door_seen_reg <= (state_reg == S_DOOR_OPEN);
            arrive_reg    <= (state_reg == S_DOOR_OPEN) && !door_seen_reg;
        end
    end

    assign current_floor = floor_reg;
    assign pending       = pending_reg;
    assign moving        = (state_reg == S_MOVE_UP) || (state_reg == S_MOVE_DOWN);
    assign dir_up        = dir_up_reg;
    assign door_open     = (state_reg == S_DOOR_OPEN);
    assign idle          = (state_reg == S_IDLE);
    assign arrive        = arrive_reg;

endmodule

// File: tb/tb_elevator_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_elevator_scan_controller
//
// Self-checking bench for elevator_scan_controller with NUM_FLOORS=8,
// MOVE_TICKS=4, DOOR_TICKS=3. A directed vector table and hand-written
// sequences check literal expectations; every cycle the outputs are also
// compared against a behavioural reference model that counts down the
// remaining travel/dwell time of the current activity.
// -----------------------------------------------------------------------------
module tb_elevator_scan_controller;

    localparam int NF = 8;
    localparam int FW = 4;
    localparam int MT = 4;
    localparam int DT = 3;

    logic          clk;
    logic          rst;
    logic [NF-1:0] call_in;
    logic          door_hold;
    logic [FW-1:0] current_floor;
    logic [NF-1:0] pending;
    logic          moving;
    logic          dir_up;
    logic          door_open;
    logic          idle;
    logic          arrive;

    int checks = 0;
    int errors = 0;

    elevator_scan_controller #(
        .NUM_FLOORS (NF),
        .FLOOR_W    (FW),
        .MOVE_TICKS (MT),
        .DOOR_TICKS (DT),
        .CNT_W      (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .call_in       (call_in),
`ifdef ELEV_DOOR_HOLD_EN
        .door_hold     (door_hold),
`endif
        .current_floor (current_floor),
        .pending       (pending),
        .moving        (moving),
        .dir_up        (dir_up),
        .door_open     (door_open),
        .idle          (idle),
        .arrive        (arrive)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 up, 2 down, 3 door; m_left = edges left in activity
    int         m_floor, m_mode, m_left, m_age;
    logic       m_dir;
    logic [7:0] m_pend;

    function automatic bit m_above();
        for (int i = 0; i < NF; i++) if (m_pend[i] && i > m_floor) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_below();
        for (int i = 0; i < NF; i++) if (m_pend[i] && i < m_floor) return 1'b1;
        return 1'b0;
    endfunction

    // Choose the next activity from the request sides (SCAN rule).
    task automatic m_choose(input bit ab, input bit bl);
        m_left = MT;
        if (ab && m_dir)       m_mode = 1;
        else if (bl && !m_dir) m_mode = 2;
        else if (ab) begin m_mode = 1; m_dir = 1'b1; end
        else if (bl) begin m_mode = 2; m_dir = 1'b0; end
        else begin m_mode = 0; m_left = 0; end
    endtask

    task automatic model_edge(input logic r, input logic [7:0] c, input logic h);
        int clr;
        bit ab, bl;
        clr = -1;
        ab  = m_above();
        bl  = m_below();
        if (r) begin
            m_floor = 0; m_pend = '0; m_dir = 1'b1; m_mode = 0; m_left = 0; m_age = 0;
            return;
        end
        case (m_mode)
            0: begin
                if (c[m_floor] || m_pend[m_floor]) begin
                    m_mode = 3; m_left = DT; m_age = 0; clr = m_floor;
                end else begin
                    m_choose(ab, bl);
                end
            end
            1, 2: begin
                m_left--;
                if (m_left == 0) begin
                    if ((m_mode == 1 && m_floor == NF - 1) || (m_mode == 2 && m_floor == 0)) begin
                        m_mode = 0;
                    end else begin
                        m_floor = m_floor + ((m_mode == 1) ? 1 : -1);
                        m_left  = MT;
                        if (c[m_floor] || m_pend[m_floor]) begin
                            m_mode = 3; m_left = DT; m_age = 0; clr = m_floor;
                        end
                    end
                end
            end
            default: begin
                clr = m_floor;
                m_age++;
                if (c[m_floor] || h) begin
                    m_left = DT;
                end else begin
                    m_left--;
                    if (m_left == 0) m_choose(ab, bl);
                end
            end
        endcase
        m_pend = m_pend | c;
        if (clr >= 0) m_pend[clr] = 1'b0;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] dut_flags();
        return {moving, dir_up, door_open, idle, arrive};
    endfunction

    task automatic compare_model();
        logic [4:0] ef;
        ef = {(m_mode == 1 || m_mode == 2), m_dir, (m_mode == 3), (m_mode == 0),
              (m_mode == 3 && m_age == 1)};
        check("model", {15'd0, current_floor, pending, dut_flags()},
                       {15'd0, FW'(m_floor), m_pend, ef});
    endtask

    // One clock edge: model sees the same inputs, outputs sampled #1 later.
    task automatic cycle();
        @(posedge clk);
        model_edge(rst, call_in, door_hold);
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        rst = 1'b1; call_in = '0; cycle(); rst = 1'b0;
    endtask

    // Let any open door close, then run until the door opens again.
    task automatic wait_door_at(input int exp_floor, input logic exp_dir, input string name);
        int n;
        n = 0;
        while (door_open && n < 100) begin cycle(); n++; end
        n = 0;
        while (!door_open && n < 200) begin cycle(); n++; end
        check({name, "_door"}, 32'(door_open), 32'd1);
        check({name, "_floor"}, 32'(current_floor), 32'(exp_floor));
        check({name, "_dir"}, 32'(dir_up), 32'(exp_dir));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       rst;
        logic [7:0] call;
        int         ncyc;
        logic [3:0] floor;
        logic [7:0] pend;
        logic [4:0] flags;   // {moving, dir_up, door_open, idle, arrive}
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{1'b1, 8'h00, 1,  4'd0, 8'h00, 5'b01010};
        vecs[1]  = '{1'b0, 8'h20, 1,  4'd0, 8'h20, 5'b01010};
        vecs[2]  = '{1'b0, 8'h00, 1,  4'd0, 8'h20, 5'b11000};
        vecs[3]  = '{1'b0, 8'h00, 4,  4'd1, 8'h20, 5'b11000};
        vecs[4]  = '{1'b0, 8'h00, 16, 4'd5, 8'h00, 5'b01100};
        vecs[5]  = '{1'b0, 8'h00, 1,  4'd5, 8'h00, 5'b01101};
        vecs[6]  = '{1'b0, 8'h00, 1,  4'd5, 8'h00, 5'b01100};
        vecs[7]  = '{1'b0, 8'h00, 1,  4'd5, 8'h00, 5'b01010};
        vecs[8]  = '{1'b1, 8'h00, 1,  4'd0, 8'h00, 5'b01010};
        vecs[9]  = '{1'b0, 8'h01, 1,  4'd0, 8'h00, 5'b01100};
        vecs[10] = '{1'b0, 8'h00, 1,  4'd0, 8'h00, 5'b01101};
        vecs[11] = '{1'b0, 8'h00, 1,  4'd0, 8'h00, 5'b01100};
        vecs[12] = '{1'b0, 8'h00, 1,  4'd0, 8'h00, 5'b01010};

        rst = 1'b1; call_in = '0; door_hold = 1'b0;
        m_floor = 0; m_mode = 0; m_left = 0; m_age = 0; m_dir = 1'b1; m_pend = '0;
        @(negedge clk);

        // Table: rst/call apply on the first cycle of a row only.
        for (int v = 0; v < 13; v++) begin
            for (int k = 0; k < vecs[v].ncyc; k++) begin
                rst     = (k == 0) ? vecs[v].rst  : 1'b0;
                call_in = (k == 0) ? vecs[v].call : 8'h00;
                cycle();
            end
            rst = 1'b0; call_in = '0;
            check($sformatf("vec%0d_floor", v), 32'(current_floor), 32'(vecs[v].floor));
            check($sformatf("vec%0d_pend", v), 32'(pending), 32'(vecs[v].pend));
            check($sformatf("vec%0d_flags", v), 32'(dut_flags()), 32'(vecs[v].flags));
        end

        // SCAN: going to 6, call 3 ahead, call 1 behind -> 3, 6, reverse to 1.
        do_reset();
        call_in = 8'h40; cycle(); call_in = '0;   // edge 0
        cycle();                                  // edge 1: start moving
        call_in = 8'h08; cycle(); call_in = '0;   // edge 2
        repeat (3) cycle();                       // edges 3..5
        check("scan_floor1", 32'(current_floor), 32'd1);
        call_in = 8'h02; cycle(); call_in = '0;   // edge 6, floor 1 already passed
        check("scan_pend", 32'(pending), 32'h4A);
        wait_door_at(3, 1'b1, "scan_stop3");
        wait_door_at(6, 1'b1, "scan_stop6");
        wait_door_at(1, 1'b0, "scan_stop1");
        for (int n = 0; n < 20 && !idle; n++) cycle();
        check("scan_idle", 32'({idle, dir_up, pending}), 32'({1'b1, 1'b0, 8'h00}));
        rst = 1'b1; cycle(); rst = 1'b0;
        check("scan_reset_dir", 32'({dir_up, idle}), 32'b11);

        // Same-floor call during dwell is absorbed and restarts the dwell.
        do_reset();
        call_in = 8'h04; cycle(); call_in = '0;
        wait_door_at(2, 1'b1, "dwell");
        cycle();                                  // 1st dwell cycle done
        call_in = 8'h04; cycle(); call_in = '0;   // sampled on the 2nd
        check("dwell_absorb", 32'({pending, door_open}), 32'({8'h00, 1'b1}));
        cycle(); check("dwell_open1", 32'(door_open), 32'd1);
        cycle(); check("dwell_open2", 32'(door_open), 32'd1);
        cycle(); check("dwell_close", 32'({door_open, idle}), 32'b01);

        // Reset mid-move between floors 3 and 4 with requests outstanding.
        do_reset();
        call_in = 8'h90; cycle(); call_in = '0;
        for (int n = 0; n < 40 && current_floor != 4'd3; n++) cycle();
        cycle();
        check("midrst_before", 32'({pending, moving, current_floor}), 32'({8'h90, 1'b1, 4'd3}));
        rst = 1'b1; cycle(); rst = 1'b0;
        check("midrst_after", 32'({current_floor, pending, dut_flags()}),
                              32'({4'd0, 8'h00, 5'b01010}));

`ifdef ELEV_DOOR_HOLD_EN
        // Door hold keeps the door open; full dwell runs after release.
        do_reset();
        call_in = 8'h01; cycle(); call_in = '0;
        check("hold_open", 32'(door_open), 32'd1);
        door_hold = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycle();
            check($sformatf("hold_cyc%0d", k), 32'(door_open), 32'd1);
        end
        door_hold = 1'b0;
        cycle(); check("hold_rel1", 32'(door_open), 32'd1);
        cycle(); check("hold_rel2", 32'(door_open), 32'd1);
        cycle(); check("hold_rel3", 32'({door_open, idle}), 32'b01);
`endif

        // Randomised traffic against the reference model.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom % 400 == 0);
            if ($urandom % 40 == 0)     call_in = 8'($urandom);
            else if ($urandom % 6 == 0) call_in = 8'(1 << ($urandom % NF));
            else                        call_in = '0;
`ifdef ELEV_DOOR_HOLD_EN
            door_hold = ($urandom % 4 == 0);
`endif
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/elevator_scan_controller.md
Name: elevator_scan_controller

Overview:
- Parametrised multi-floor elevator controller.
- Latches one call button per floor into a pending-request register and serves requests with a SCAN (keep-direction) policy.
- Applies a per-floor travel delay and a door-open dwell time.
- Sits between the board input pins and the floor display decoder. It drives the current floor index plus status flags to the top-level output pins.

Parameters:
- NUM_FLOORS, 8: number of floors, indexed 0..NUM_FLOORS-1. Legal range 2..16.
- FLOOR_W, 4: width of the floor index. Must satisfy 2^FLOOR_W >= NUM_FLOORS.
- MOVE_TICKS, 10000000: clock cycles spent travelling between adjacent floors. Must be >= 1.
- DOOR_TICKS, 20000000: clock cycles the door stays open per stop. Must be >= 1.
- CNT_W, 32: width of the shared delay counter. Must hold max(MOVE_TICKS, DOOR_TICKS).

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- call_in, input, NUM_FLOORS: call buttons, one per floor. Bit i high on a sampled edge requests floor i. Pulse or level both accepted.
- current_floor, output, FLOOR_W: registered index of the floor last reached.
- pending, output, NUM_FLOORS: registered outstanding-request mask.
- moving, output, 1: high in MOVE_UP or MOVE_DOWN.
- dir_up, output, 1: last or current travel direction (1 = up).
- door_open, output, 1: high in DOOR_OPEN.
- idle, output, 1: high in IDLE.
- arrive, output, 1: one-cycle pulse on the edge after entering DOOR_OPEN.

Behaviour:
- Reset values: current_floor=0, pending=0, dir_up=1, state=IDLE, counter=0, door_open=0, moving=0, arrive=0, idle=1.
- Pending register: each edge, pending <= (pending | call_in) & ~clear_mask.
  - clear_mask is the bit of the floor being served on that edge.
  - Clear wins over a same-cycle set for the same floor (the call is absorbed).
- Definitions: "above" = any pending bit > current_floor; "below" = any pending bit < current_floor.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN. Outputs are decoded from registered state.
- IDLE transitions, in priority order:
  - call_in or pending set at current_floor -> DOOR_OPEN; clear that bit.
  - Else above and dir_up -> MOVE_UP.
  - Else below and !dir_up -> MOVE_DOWN.
  - Else above -> MOVE_UP with dir_up<=1.
  - Else below -> MOVE_DOWN with dir_up<=0.
  - Else stay in IDLE.
- MOVE_UP / MOVE_DOWN:
  - Counter resets to 0 on state entry and increments each cycle.
  - When counter == MOVE_TICKS-1: current_floor steps ±1 and the counter resets.
  - On that same edge, if the stepped-to floor's pending bit (or call_in bit) is set: go to DOOR_OPEN and clear the bit.
  - Otherwise continue moving.
- Floor bounds: current_floor never goes below 0 or above NUM_FLOORS-1. The direction logic guarantees this; if violated, the FSM goes to IDLE and the floor holds.
- DOOR_OPEN:
  - Counter runs for exactly DOOR_TICKS cycles.
  - A call for current_floor while in DOOR_OPEN is absorbed (the bit is not set) and restarts the dwell counter.
  - On expiry: above && dir_up -> MOVE_UP; below && !dir_up -> MOVE_DOWN; else reverse if the opposite side has requests (updating dir_up); else IDLE.
- Calls arriving mid-move for the current_floor index (already passed) are latched and served on a later visit.
- rst asserted in any state returns all registers to reset values on the next edge. Pending requests are discarded.

Optional Feature:
- Macro ELEV_DOOR_HOLD_EN.
- Defined: adds input port door_hold (1 bit).
  - While door_hold=1 in DOOR_OPEN, the counter is held at 0, so the door stays open.
  - Dwell of DOOR_TICKS cycles resumes from release.
  - door_hold is ignored in other states.
- Undefined: the port is absent and dwell is always exactly DOOR_TICKS (plus any same-floor-call restarts).

Test Plan (NUM_FLOORS=8, FLOOR_W=4, MOVE_TICKS=4, DOOR_TICKS=3):
1. Reset, then call_in[5] pulsed, sampled at edge 0 -> MOVE_UP from edge 1; current_floor=1,2,3,4,5 at edges 5,9,13,17,21; DOOR_OPEN from edge 21; arrive pulse at edge 22; pending[5] cleared; IDLE at edge 24.
2. Idle at floor 0, call_in[0] pulsed -> DOOR_OPEN next edge, door_open=1 for 3 cycles, pending stays 0, no motion.
3. Moving up from 0 toward 6, call_in[3] pulsed before floor 3 is reached and call_in[1] pulsed after floor 1 is passed -> stops at 3, then 6, then reverses (dir_up=0) to 1, then IDLE.
4. Door open at floor 2, call_in[2] pulsed on the 2nd dwell cycle -> pending[2] stays 0 and door_open stays high for 3 further cycles.
5. rst asserted mid-move between floors 3 and 4 with pending=8'b1001_0000 -> next edge current_floor=0, pending=0, idle=1, dir_up=1.
6. With ELEV_DOOR_HOLD_EN: door_hold high for 10 cycles during DOOR_OPEN -> door_open stays high throughout, then closes 3 cycles after release.
